// File: rtl/stopwatch_uart_tx_pkg.sv
// Shared constants, state types and ASCII helpers for the stopwatch UART transmitter.
// Frame layout is d3 d2 SEP d1 d0 CR LF.
package stopwatch_uart_tx_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_UNK  = 8'h3F;
   localparam int         FRAME_LEN  = 7;

   typedef enum logic {
      F_IDLE,
      F_SEND
   } frame_state_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } byte_state_t;

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble);
      if (nibble <= 4'd9) begin
         return ASCII_ZERO + {4'h0, nibble};
      end
      return ASCII_UNK;
   endfunction

   // Index 7 and above fall through to LF; the top never launches those.
   function automatic logic [7:0] frame_byte(input logic [15:0] digits,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  sep);
      case (idx)
         3'd0:    return bcd_to_ascii(digits[15:12]);
         3'd1:    return bcd_to_ascii(digits[11:8]);
         3'd2:    return sep;
         3'd3:    return bcd_to_ascii(digits[7:4]);
         3'd4:    return bcd_to_ascii(digits[3:0]);
         3'd5:    return ASCII_CR;
         default: return ASCII_LF;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_uart_tx_if.sv
// Request/status bundle between the stopwatch core and the UART transmitter.
// The slave modport is the transmitter side.
interface stopwatch_uart_tx_if;

   logic        send;
   logic [15:0] digits;
   logic        busy;
   logic        frame_done;
   logic        usb_tx;

   modport master (
      output send,
      output digits,
      input  busy,
      input  frame_done,
      input  usb_tx
   );

   modport slave (
      input  send,
      input  digits,
      output busy,
      output frame_done,
      output usb_tx
   );

endinterface

// File: rtl/stopwatch_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// A start request on the final stop cycle chains straight into the next start bit.
module uart_tx_byte
   import stopwatch_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       byte_done
);

   localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   byte_state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bit_idx, bit_idx_d;
   logic [7:0]    shreg, shreg_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shreg   <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d is the line level for the next cycle, so the pin is a plain flop output.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + CW'(1);
      bit_idx_d = bit_idx;
      shreg_d   = shreg;
      tx_d      = tx_q;
      byte_done = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (start) begin
               state_d = START;
               shreg_d = data;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               cnt_d     = '0;
               bit_idx_d = '0;
               tx_d      = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_idx == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx + 3'd1;
                  shreg_d   = {1'b0, shreg[7:1]};
                  tx_d      = shreg[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               byte_done = 1'b1;
               cnt_d     = '0;
               if (start) begin
                  state_d = START;
                  shreg_d = data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx   = tx_q;
   assign busy = (state != IDLE);

endmodule

// File: rtl/stopwatch_uart_tx.sv
// Sends the latched 4-digit BCD reading as "d3d2:d1d0\r\n" over an 8N1 UART line.
// Frame sequencing and digit encoding live here; bit timing lives in uart_tx_byte.
module stopwatch_uart_tx
   import stopwatch_uart_tx_pkg::*;
#(
   parameter int         CLK_FREQ = 100000000,
   parameter int         BAUD     = 115200,
   parameter logic [7:0] SEP_CHAR = 8'h3A
) (
   input  logic                 clk,
   input  logic                 rst,
   stopwatch_uart_tx_if.slave   bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   frame_state_t f_state, f_next;
   logic [15:0]  frame_q;
   logic [2:0]   byte_idx;
   logic [2:0]   sel_idx;
   logic         launch_q, launch_d;
   logic         accept;
   logic         last_done;
   logic         busy_int;
   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_tx;
   logic         byte_busy;
   logic         byte_done;

   // busy drops during the final stop cycle so a waiting send is taken on the very next edge.
   assign last_done = (f_state == F_SEND) && byte_done && (byte_idx == 3'(FRAME_LEN - 1));
   assign busy_int  = (f_state == F_SEND) && !last_done;
   assign accept    = bus.send && !busy_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_state  <= F_IDLE;
         frame_q  <= '0;
         byte_idx <= '0;
         launch_q <= 1'b0;
      end else begin
         f_state  <= f_next;
         launch_q <= launch_d;
         if (accept) begin
            frame_q  <= bus.digits;
            byte_idx <= '0;
         end else if ((f_state == F_SEND) && byte_done) begin
            byte_idx <= byte_idx + 3'd1;
         end
      end
   end

   always_comb begin
      f_next   = f_state;
      launch_d = accept;
      case (f_state)
         F_IDLE: begin
            if (accept) begin
               f_next = F_SEND;
            end
         end
         F_SEND: begin
            if (last_done && !accept) begin
               f_next = F_IDLE;
            end
         end
         default: f_next = F_IDLE;
      endcase
   end

   // The next byte is presented during the current byte's last stop cycle to avoid a gap.
   always_comb begin
      sel_idx    = byte_done ? (byte_idx + 3'd1) : byte_idx;
      byte_start = (launch_q && !byte_busy) ||
                   ((f_state == F_SEND) && byte_done && !last_done);
      byte_data  = frame_byte(frame_q, sel_idx, SEP_CHAR);
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk       (clk),
      .rst       (rst),
      .start     (byte_start),
      .data      (byte_data),
      .tx        (byte_tx),
      .busy      (byte_busy),
      .byte_done (byte_done)
   );

   assign bus.usb_tx     = byte_tx;
   assign bus.busy       = busy_int;
   assign bus.frame_done = last_done;

endmodule

// File: doc/stopwatch_uart_tx.md
Name: stopwatch_uart_tx

Overview:
Transmit-side counterpart to the board's usb_rx path. It serialises the stopwatch's current 4-digit BCD reading as an ASCII frame on usb_tx (8N1 UART), for example "12:34\r\n".
- Sits in au_top between the Counter/BCD_n digit outputs and the usb_tx pin.
- Sends one frame per accepted `send` pulse, typically one per displayed-value change or one per second.

Parameters:
CLK_FREQ, 100000000, clk frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
SEP_CHAR, 8'h3A, separator byte sent between digit pairs (':')

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
send  input  1  one-cycle request to transmit the current digits
digits  input  16  BCD digits: [15:12]=d3 (MSD) ... [3:0]=d0 (LSD)
busy  output  1  high while a frame is in progress
frame_done  output  1  one-cycle pulse when the last stop bit completes
usb_tx  output  1  UART line, idle high

Behaviour:
- Reset (async): usb_tx=1, busy=0, frame_done=0, all counters=0, both FSMs idle. Reset mid-frame aborts the frame immediately; usb_tx returns high with no glitch low. No resumption after reset.
- Accept rule:
  - `send` is sampled on a clk edge where registered busy==0.
  - That edge latches `digits` into a frame register and sets busy=1.
  - `send` while busy=1 is ignored; it is not queued.
  - Later changes on `digits` do not affect the frame in progress.
- Frame is exactly 7 bytes: d3, d2, SEP_CHAR, d1, d0, 8'h0D, 8'h0A.
- Digit encoding:
  - A BCD nibble 0..9 is sent as 8'h30+nibble.
  - Nibbles 10..15 are sent as 8'h3F ('?').
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Latency: usb_tx drives the first start bit (low) on the edge after the accepting edge, i.e. 1 cycle.
- Bytes are back-to-back: the next start bit begins on the cycle after the previous stop bit's last cycle. There is no idle gap.
- Total frame time: 70*CLKS_PER_BIT cycles from first start bit to end of last stop bit.
- At end of last stop bit: frame_done=1 for one cycle, and busy falls on the same edge. A `send` present on the next edge is accepted, giving a minimum 1-cycle idle-high gap between frames.
- Frame FSM (top): F_IDLE -> F_SEND (byte index 0..6, issue byte, wait byte_done) -> F_IDLE after index 6 completes.
- Byte FSM (sub-module): IDLE -> START -> DATA (bit index 0..7) -> STOP -> IDLE.
  - The baud counter counts 0..CLKS_PER_BIT-1 and reloads on state change.
  - byte_done pulses on the last STOP cycle.
  - A new `start` arriving in that same cycle goes directly to START.
- usb_tx is driven straight from a flop, with no combinational path to the pin.

Decomposition:
- Shared package/header holds the ASCII constants: ASCII_ZERO 8'h30, ASCII_CR 8'h0D, ASCII_LF 8'h0A, ASCII_UNK 8'h3F, and FRAME_LEN 7.
- One sub-module, uart_tx_byte (CLKS_PER_BIT param), with ports:
  - inputs: clk, rst, start, data[7:0]
  - outputs: tx, busy, byte_done
- The top handles frame sequencing and digit-to-ASCII encoding.

Test Plan:
1. Use CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10), digits=16'h1234, pulse send -> usb_tx low exactly 1 cycle later. The decoded bytes are 31 32 3A 33 34 0D 0A. frame_done pulses at cycle 700 after first start; busy=1 for those 700 cycles.
2. digits=16'h9A05 -> bytes 39 3F 3A 30 35 0D 0A.
3. Pulse send again at cycles 50 and 300 of an active frame, and change digits mid-frame -> exactly one frame is sent, carrying the originally latched digits.
4. Hold send high continuously with digits=16'h0000 -> consecutive frames "00:00\r\n" separated by exactly 1 idle-high cycle. frame_done pulses every 701 cycles.
5. Assert rst during bit 3 of byte 2 -> usb_tx=1, busy=0, frame_done=0 with no clk edge needed. After release, send with digits=16'h5959 produces a clean frame "59:59\r\n".
6. Check each bit width: measure every usb_tx transition interval over one frame -> all intervals are multiples of 10 cycles, and the stop bits are high for at least 10 cycles.
